// File: rtl/decode_stage.sv
// Decode stage: IF/ID pipeline register, integer register file with write-through
// bypass, and the instruction decoder producing ID/EX controls and immediates.
module decode_stage #(
  parameter int data_width    = 32,
  parameter int address_width = 12,
  parameter int reg_count     = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [data_width-1:0]    if_instruction,
  input  logic [address_width-1:0] if_pc,
  input  logic [address_width-1:0] if_pc_plus_4,
  input  logic                     wb_reg_write,
  input  logic [4:0]               wb_rd,
  input  logic [data_width-1:0]    wb_data,
  output logic                     id_valid,
  output logic [address_width-1:0] id_pc,
  output logic [address_width-1:0] id_pc_plus_4,
  output logic [4:0]               id_rs1,
  output logic [4:0]               id_rs2,
  output logic [4:0]               id_rd,
  output logic [2:0]               id_funct3,
  output logic                     id_funct7_5,
  output logic [data_width-1:0]    id_rs1_data,
  output logic [data_width-1:0]    id_rs2_data,
  output logic [data_width-1:0]    id_imm,
  output logic                     id_reg_write,
  output logic                     id_mem_read,
  output logic                     id_mem_write,
  output logic                     id_mem_to_reg,
  output logic                     id_alu_src,
  output logic                     id_branch,
  output logic                     id_jump,
  output logic [1:0]               id_alu_op,
  output logic                     id_illegal
);

  localparam logic [31:0] nop_instr = 32'h0000_0013;

  localparam logic [6:0] op_r      = 7'b0110011;
  localparam logic [6:0] op_imm    = 7'b0010011;
  localparam logic [6:0] op_load   = 7'b0000011;
  localparam logic [6:0] op_store  = 7'b0100011;
  localparam logic [6:0] op_branch = 7'b1100011;
  localparam logic [6:0] op_jal    = 7'b1101111;
  localparam logic [6:0] op_jalr   = 7'b1100111;
  localparam logic [6:0] op_lui    = 7'b0110111;
  localparam logic [6:0] op_auipc  = 7'b0010111;

  logic [31:0]              instr_q, instr_d;
  logic [address_width-1:0] pc_q, pc_d;
  logic [address_width-1:0] pc_plus_4_q, pc_plus_4_d;
  logic                     valid_q, valid_d;

  logic [data_width-1:0] rf_q [1:reg_count-1];
  logic [data_width-1:0] rf_d [1:reg_count-1];
  logic                  wb_en_s;

  logic [6:0]            opcode_s;
  logic [4:0]            rd_s;
  logic [4:0]            rs1_s;
  logic [4:0]            rs2_s;
  logic [data_width-1:0] rs1_rf_s;
  logic [data_width-1:0] rs2_rf_s;

  logic       c_reg_write_s;
  logic       c_mem_read_s;
  logic       c_mem_write_s;
  logic       c_mem_to_reg_s;
  logic       c_alu_src_s;
  logic       c_branch_s;
  logic       c_jump_s;
  logic [1:0] c_alu_op_s;
  logic       c_illegal_s;

  // IF/ID next state: flush beats stall, stall beats load
  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    pc_plus_4_d = pc_plus_4_q;
    valid_d     = valid_q;
    if (flush) begin
      instr_d     = nop_instr;
      pc_d        = '0;
      pc_plus_4_d = '0;
      valid_d     = 1'b0;
    end else if (stall) begin
      instr_d     = instr_q;
      pc_d        = pc_q;
      pc_plus_4_d = pc_plus_4_q;
      valid_d     = valid_q;
    end else begin
      instr_d     = if_instruction;
      pc_d        = if_pc;
      pc_plus_4_d = if_pc_plus_4;
      valid_d     = 1'b1;
    end
  end

  // IF/ID register; reset loads the same bubble as a flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q     <= nop_instr;
      pc_q        <= '0;
      pc_plus_4_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      pc_plus_4_q <= pc_plus_4_d;
      valid_q     <= valid_d;
    end
  end

  assign wb_en_s = wb_reg_write && (wb_rd != 5'd0);

  // Register file next state; x0 has no storage so writes to it vanish
  always_comb begin
    for (int i = 1; i < reg_count; i++) begin
      if (wb_en_s && (wb_rd == 5'(i))) begin
        rf_d[i] = wb_data;
      end else begin
        rf_d[i] = rf_q[i];
      end
    end
  end

  // Register file storage; writes ignore stall and flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < reg_count; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < reg_count; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign opcode_s = instr_q[6:0];
  assign rd_s     = instr_q[11:7];
  assign rs1_s    = instr_q[19:15];
  assign rs2_s    = instr_q[24:20];

  // Asynchronous operand read; x0 falls through to the zero default
  always_comb begin
    rs1_rf_s = '0;
    rs2_rf_s = '0;
    for (int i = 1; i < reg_count; i++) begin
      if (rs1_s == 5'(i)) begin
        rs1_rf_s = rf_q[i];
      end else begin
        rs1_rf_s = rs1_rf_s;
      end
      if (rs2_s == 5'(i)) begin
        rs2_rf_s = rf_q[i];
      end else begin
        rs2_rf_s = rs2_rf_s;
      end
    end
  end

  // Write-through bypass so a same-cycle WB result is seen without waiting an edge
  always_comb begin
    if (wb_en_s && (wb_rd == rs1_s)) begin
      id_rs1_data = wb_data;
    end else begin
      id_rs1_data = rs1_rf_s;
    end
    if (wb_en_s && (wb_rd == rs2_s)) begin
      id_rs2_data = wb_data;
    end else begin
      id_rs2_data = rs2_rf_s;
    end
  end

  // Control decode by opcode, before valid / rd gating
  always_comb begin
    c_reg_write_s  = 1'b0;
    c_mem_read_s   = 1'b0;
    c_mem_write_s  = 1'b0;
    c_mem_to_reg_s = 1'b0;
    c_alu_src_s    = 1'b0;
    c_branch_s     = 1'b0;
    c_jump_s       = 1'b0;
    c_alu_op_s     = 2'b00;
    c_illegal_s    = 1'b0;
    case (opcode_s)
      op_r: begin
        c_reg_write_s = 1'b1;
        c_alu_op_s    = 2'b10;
      end
      op_imm: begin
        c_reg_write_s = 1'b1;
        c_alu_src_s   = 1'b1;
        c_alu_op_s    = 2'b11;
      end
      op_load: begin
        c_reg_write_s  = 1'b1;
        c_mem_read_s   = 1'b1;
        c_mem_to_reg_s = 1'b1;
        c_alu_src_s    = 1'b1;
      end
      op_store: begin
        c_mem_write_s = 1'b1;
        c_alu_src_s   = 1'b1;
      end
      op_branch: begin
        c_branch_s = 1'b1;
        c_alu_op_s = 2'b01;
      end
      op_jal, op_jalr: begin
        c_reg_write_s = 1'b1;
        c_jump_s      = 1'b1;
        c_alu_src_s   = 1'b1;
      end
      op_lui, op_auipc: begin
        c_reg_write_s = 1'b1;
        c_alu_src_s   = 1'b1;
      end
      default: begin
        c_illegal_s = 1'b1;
      end
    endcase
  end

  // Immediate generation; sign always comes from instr[31]
  always_comb begin
    id_imm = '0;
    case (opcode_s)
      op_load, op_imm, op_jalr: id_imm = {{20{instr_q[31]}}, instr_q[31:20]};
      op_store:  id_imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      op_branch: id_imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                           instr_q[30:25], instr_q[11:8], 1'b0};
      op_lui, op_auipc: id_imm = {instr_q[31:12], 12'h000};
      op_jal:    id_imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                           instr_q[20], instr_q[30:21], 1'b0};
      default:   id_imm = '0;
    endcase
  end

  assign id_valid     = valid_q;
  assign id_pc        = pc_q;
  assign id_pc_plus_4 = pc_plus_4_q;
  assign id_rs1       = rs1_s;
  assign id_rs2       = rs2_s;
  assign id_rd        = rd_s;
  assign id_funct3    = instr_q[14:12];
  assign id_funct7_5  = instr_q[30];

  // A bubble must never look like work downstream, and rd=x0 never writes back
  assign id_reg_write  = valid_q && c_reg_write_s && (rd_s != 5'd0);
  assign id_mem_read   = valid_q && c_mem_read_s;
  assign id_mem_write  = valid_q && c_mem_write_s;
  assign id_mem_to_reg = valid_q && c_mem_to_reg_s;
  assign id_alu_src    = valid_q && c_alu_src_s;
  assign id_branch     = valid_q && c_branch_s;
  assign id_jump       = valid_q && c_jump_s;
  assign id_alu_op     = valid_q ? c_alu_op_s : 2'b00;
  assign id_illegal    = valid_q && c_illegal_s;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised and directed bench for decode_stage, checked every cycle against an
// instruction-level reference model plus hand-computed expectations.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic [31:0] if_instruction;
  logic [11:0] if_pc, if_pc_plus_4;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        id_valid;
  logic [11:0] id_pc, id_pc_plus_4;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        id_alu_src, id_branch, id_jump, id_illegal;
  logic [1:0]  id_alu_op;

  decode_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .if_instruction(if_instruction), .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus_4(id_pc_plus_4),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7_5(id_funct7_5),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_alu_src(id_alu_src), .id_branch(id_branch), .id_jump(id_jump),
    .id_alu_op(id_alu_op), .id_illegal(id_illegal)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic chk_en = 1'b0;

  // Reference state: the fetched instruction in flight and the architectural registers
  logic [31:0] m_instr;
  logic [11:0] m_pc, m_pc4;
  logic        m_valid;
  logic [31:0] m_regs [32];

  typedef struct packed {
    logic       rw, mr, mw, m2r, as, br, jp;
    logic [1:0] op;
    logic       ill;
  } ctrl_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic ctrl_t ref_ctrl(input logic [31:0] ins);
    ctrl_t c = '0;
    case (ins[6:0])
      7'h33:        begin c.rw = 1'b1; c.op = 2'd2; end
      7'h13:        begin c.rw = 1'b1; c.as = 1'b1; c.op = 2'd3; end
      7'h03:        begin c.rw = 1'b1; c.mr = 1'b1; c.m2r = 1'b1; c.as = 1'b1; end
      7'h23:        begin c.mw = 1'b1; c.as = 1'b1; end
      7'h63:        begin c.br = 1'b1; c.op = 2'd1; end
      7'h6F, 7'h67: begin c.rw = 1'b1; c.jp = 1'b1; c.as = 1'b1; end
      7'h37, 7'h17: begin c.rw = 1'b1; c.as = 1'b1; end
      default:      c.ill = 1'b1;
    endcase
    return c;
  endfunction

  // Immediate value as a signed integer, built from the encoded field weights
  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int v = 0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67: begin
        v = int'(ins[31:20]);
        if (ins[31]) v = v - 4096;
      end
      7'h23: begin
        v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
        if (ins[31]) v = v - 4096;
      end
      7'h63: begin
        v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        if (ins[31]) v = v - 4096;
      end
      7'h37, 7'h17: v = int'(ins & 32'hFFFF_F000);
      7'h6F: begin
        v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        if (ins[31]) v = v - (1 << 20);
      end
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] r);
    if (wb_reg_write && wb_rd != 5'd0 && wb_rd == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_bubble();
    m_instr = 32'h0000_0013;
    m_pc    = 12'h000;
    m_pc4   = 12'h000;
    m_valid = 1'b0;
  endtask

  task automatic model_reset();
    model_bubble();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
    end else begin
      if (wb_reg_write && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
      if (flush) model_bubble();
      else if (!stall) begin
        m_instr = if_instruction;
        m_pc    = if_pc;
        m_pc4   = if_pc_plus_4;
        m_valid = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [11:0] pc,
                       input logic st, input logic fl, input logic we,
                       input logic [4:0] rd, input logic [31:0] d);
    if_instruction = ins;
    if_pc          = pc;
    if_pc_plus_4   = pc + 12'd4;
    stall          = st;
    flush          = fl;
    wb_reg_write   = we;
    wb_rd          = rd;
    wb_data        = d;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      ctrl_t c;
      c = ref_ctrl(m_instr);
      if (!m_valid) c = '0;
      if (m_instr[11:7] == 5'd0) c.rw = 1'b0;
      chk("valid",     id_valid,     m_valid);
      chk("pc",        id_pc,        m_pc);
      chk("pc_plus_4", id_pc_plus_4, m_pc4);
      chk("rs1",       id_rs1,       m_instr[19:15]);
      chk("rs2",       id_rs2,       m_instr[24:20]);
      chk("rd",        id_rd,        m_instr[11:7]);
      chk("funct3",    id_funct3,    m_instr[14:12]);
      chk("funct7_5",  id_funct7_5,  m_instr[30]);
      chk("rs1_data",  id_rs1_data,  ref_read(m_instr[19:15]));
      chk("rs2_data",  id_rs2_data,  ref_read(m_instr[24:20]));
      chk("imm",       id_imm,       ref_imm(m_instr));
      chk("controls",
          {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
           id_branch, id_jump, id_alu_op, id_illegal},
          c);
    end
  end

  logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                           7'h67, 7'h37, 7'h17, 7'h00, 7'h7F};

  initial begin
    logic [31:0] r;
    reset = 1'b1;
    drive(32'h0000_0013, 12'h000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    model_reset();
    step();
    chk("reset valid",  id_valid,  32'h0);
    chk("reset pc",     id_pc,     32'h0);
    chk("reset alu_op", id_alu_op, 32'h0);
    chk("reset imm",    id_imm,    32'h0);
    chk_en = 1'b1;
    reset  = 1'b0;

    drive(32'h0000_0013, 12'h000, 1'b0, 1'b0, 1'b1, 5'd1, 32'd5);
    step();
    drive(32'h0020_81B3, 12'h010, 1'b0, 1'b0, 1'b1, 5'd2, 32'd7);
    step();
    chk("add rs1_data", id_rs1_data,  32'd5);
    chk("add rs2_data", id_rs2_data,  32'd7);
    chk("add rd",       id_rd,        32'd3);
    chk("add reg_write", id_reg_write, 32'd1);
    chk("add alu_op",   id_alu_op,    32'd2);
    chk("add pc4",      id_pc_plus_4, 32'h014);

    drive(32'h0081_2283, 12'h020, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    drive(32'h0000_0033, 12'h024, 1'b1, 1'b0, 1'b1, 5'd2, 32'h100);
    #1;
    chk("lw bypass",     id_rs1_data,   32'h100);
    chk("lw imm",        id_imm,        32'd8);
    chk("lw mem_read",   id_mem_read,   32'd1);
    chk("lw mem_to_reg", id_mem_to_reg, 32'd1);
    chk("lw alu_src",    id_alu_src,    32'd1);
    step();

    drive(32'hFE51_2E23, 12'h028, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("sw imm",       id_imm,       32'hFFFF_FFFC);
    chk("sw mem_write", id_mem_write, 32'd1);
    chk("sw reg_write", id_reg_write, 32'd0);
    drive(32'hFE20_8CE3, 12'h02C, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("beq imm",    id_imm,    32'hFFFF_FFF8);
    chk("beq branch", id_branch, 32'd1);
    chk("beq alu_op", id_alu_op, 32'd1);

    drive(32'h0020_81B3, 12'h040, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive($urandom(), 12'(i * 4 + 12'h080), 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
      step();
      chk("stall pc",        id_pc,        32'h040);
      chk("stall rd",        id_rd,        32'd3);
      chk("stall reg_write", id_reg_write, 32'd1);
    end
    drive(32'h0020_81B3, 12'h090, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0);
    step();
    chk("flush valid",     id_valid,     32'd0);
    chk("flush rs1",       id_rs1,       32'd0);
    chk("flush imm",       id_imm,       32'd0);
    chk("flush reg_write", id_reg_write, 32'd0);
    chk("flush alu_op",    id_alu_op,    32'd0);

    drive(32'h0000_0000, 12'h0A0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("illegal flag",      id_illegal,   32'd1);
    chk("illegal reg_write", id_reg_write, 32'd0);
    chk("illegal imm",       id_imm,       32'd0);

    drive(32'h0000_0033, 12'h0A4, 1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step();
    chk("x0 no bypass", id_rs1_data, 32'h0);
    drive(32'h0000_0033, 12'h0A8, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("x0 reads zero", id_rs1_data, 32'h0);

    drive(32'h0010_8013, 12'h0B0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("rd0 reg_write", id_reg_write, 32'd0);
    chk("rd0 alu_src",   id_alu_src,   32'd1);
    chk("rd0 imm",       id_imm,       32'd1);

    for (int n = 0; n < 400; n++) begin
      r = $urandom();
      drive({r[31:7], ops[$urandom_range(10, 0)]}, 12'($urandom()),
            ($urandom_range(9, 0) < 2), ($urandom_range(9, 0) < 1),
            ($urandom_range(3, 0) != 0), 5'($urandom()), $urandom());
      step();
    end

    drive(32'h0000_0013, 12'h000, 1'b0, 1'b0, 1'b1, 5'd1, 32'h0000_0ABC);
    step();
    drive(32'h0020_81B3, 12'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    chk("pre-reset valid", id_valid, 32'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("async reset valid",     id_valid,     32'd0);
    chk("async reset pc",        id_pc,        32'd0);
    chk("async reset reg_write", id_reg_write, 32'd0);
    chk("async reset alu_op",    id_alu_op,    32'd0);
    step();
    reset = 1'b0;
    step();
    chk("post-reset x1", id_rs1_data, 32'h0);
    chk("post-reset x2", id_rs2_data, 32'h0);
    step();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
